// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the four-way round-robin mux arbiter.
// rr_pick returns {found, idx}: the first requester strictly after 'last', wrapping, with 'last' itself tried last.
package mux4_arb_pkg;

    typedef enum logic {S_IDLE, S_GRANT} arb_state_t;

    localparam logic [3:0] GRANT_NONE = 4'b0000;

    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        // Walk from farthest to nearest so the nearest hit overwrites earlier ones.
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Valid/ready bundle between four producers, the arbiter and one consumer.
// master = producer/consumer side, slave = arbiter side.
interface mux4_rr_arbiter_if #(
    parameter int N = 1
);
    logic [N-1:0] in0_data;
    logic [N-1:0] in1_data;
    logic [N-1:0] in2_data;
    logic [N-1:0] in3_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   grant;
    logic         busy;

    modport master (
        output in0_data, in1_data, in2_data, in3_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, grant, busy
    );

    modport slave (
        input  in0_data, in1_data, in2_data, in3_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, grant, busy
    );
endinterface

// File: rtl/mux4_rr_arbiter_mux4.sv
// Plain combinational 4:1 data mux, N bits wide.
module mux4 #(
    parameter int N = 1
) (
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic [N-1:0] d2,
    input  logic [N-1:0] d3,
    input  logic [1:0]   sel,
    output logic [N-1:0] y
);
    always_comb begin
        y = d0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 mux onto one valid/ready output.
// Define MUX4_ARB_BURST_EN to let an owner keep the grant for up to BURST_LEN beats.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int N         = 1,
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux4_rr_arbiter_if.slave     bus
);
    arb_state_t state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] last_q, last_d;
    logic [3:0] grant_q, grant_d;

    logic [N-1:0] mux_y;
    logic         sel_valid;
    logic         xfer;
    logic         rearb;
    logic [2:0]   pick;

`ifdef MUX4_ARB_BURST_EN
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             burst_more;
`endif

    mux4 #(.N(N)) u_mux4 (
        .d0  (bus.in0_data),
        .d1  (bus.in1_data),
        .d2  (bus.in2_data),
        .d3  (bus.in3_data),
        .sel (sel_q),
        .y   (mux_y)
    );

    always_comb begin
        sel_valid = bus.in_valid[sel_q];
        xfer      = (state_q == S_GRANT) && sel_valid && bus.out_ready;
        // While granted, the current owner is the pointer, so it drops to lowest priority.
        pick      = rr_pick(bus.in_valid, (state_q == S_GRANT) ? sel_q : last_q);
`ifdef MUX4_ARB_BURST_EN
        burst_more = sel_valid && ((int'(cnt_q) + 1) < BURST_LEN);
`endif
    end

    always_comb begin
        bus.out_data  = mux_y;
        bus.out_valid = 1'b0;
        bus.in_ready  = 4'b0000;
        bus.grant     = grant_q;
        bus.busy      = 1'b0;
        if (state_q == S_GRANT) begin
            bus.out_valid        = sel_valid;
            bus.in_ready[sel_q]  = bus.out_ready;
            bus.busy             = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        grant_d = grant_q;
        rearb   = 1'b0;
`ifdef MUX4_ARB_BURST_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                rearb = 1'b1;
            end
            S_GRANT: begin
                if (xfer) begin
                    last_d = sel_q;
                    rearb  = 1'b1;
`ifdef MUX4_ARB_BURST_EN
                    if (burst_more) begin
                        rearb = 1'b0;
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end else if (!sel_valid) begin
                    state_d = S_IDLE;
                    grant_d = GRANT_NONE;
                    last_d  = sel_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = GRANT_NONE;
            end
        endcase

        if (rearb) begin
            if (pick[2]) begin
                state_d = S_GRANT;
                sel_d   = pick[1:0];
                grant_d = 4'b0001 << pick[1:0];
`ifdef MUX4_ARB_BURST_EN
                cnt_d   = '0;
`endif
            end else begin
                state_d = S_IDLE;
                grant_d = GRANT_NONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            grant_q <= GRANT_NONE;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

`ifdef MUX4_ARB_BURST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench: a cycle model of the round-robin rules queues the expected outputs,
// and an independent monitor compares them with the DUT on every falling edge.
module tb_mux4_rr_arbiter;

    localparam int N         = 8;
    localparam int BURST_LEN = 4;
`ifdef MUX4_ARB_BURST_EN
    localparam int BEATS = BURST_LEN;
`else
    localparam int BEATS = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux4_rr_arbiter_if #(.N(N)) bus();

    mux4_rr_arbiter #(.N(N), .BURST_LEN(BURST_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic         ov;
        logic [N-1:0] data;
        logic [3:0]   grant;
        logic [3:0]   rdy;
        logic         busy;
    } obs_t;

    obs_t exp_q[$];
    obs_t log_q[$];
    obs_t mon_e, mon_a;
    int   checks = 0;
    int   passed = 0;
    int   mon_cyc = 0;

    // Reference model: owner index (-1 idle), last served port, beats given in this grant.
    int           m_owner = -1;
    int           m_last  = 3;
    int           m_beats = 0;
    logic [N-1:0] d [4];

    logic [3:0]   r;
    logic [3:0]   pend;
    logic         ordy;
    int           base;
    logic [3:0]   t1_exp [5];
    logic [3:0]   t5_exp [8];

    function automatic int next_rr(logic [3:0] v, int from);
        for (int k = 1; k <= 4; k++) begin
            int p;
            p = (from + k) % 4;
            if (v[p]) return p;
        end
        return -1;
    endfunction

    function automatic obs_t model_expect(logic [3:0] v, logic o_rdy);
        obs_t e;
        e = '0;
        if (m_owner >= 0) begin
            e.busy         = 1'b1;
            e.grant        = 4'b0001 << m_owner;
            e.ov           = v[m_owner];
            e.data         = d[m_owner];
            e.rdy[m_owner] = o_rdy;
        end
        return e;
    endfunction

    task automatic model_step(logic [3:0] v, logic o_rdy);
        if (m_owner < 0) begin
            m_owner = next_rr(v, m_last);
            m_beats = 0;
        end else if (v[m_owner] && o_rdy) begin
            m_beats++;
            m_last = m_owner;
            if (m_beats >= BEATS) begin
                m_owner = next_rr(v, m_owner);
                m_beats = 0;
            end
        end else if (!v[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, got, want);
    endtask

    task automatic cycle(logic [3:0] v, logic o_rdy, output logic [3:0] rdy_exp);
        obs_t e;
        bus.in_valid  = v;
        bus.out_ready = o_rdy;
        bus.in0_data  = d[0];
        bus.in1_data  = d[1];
        bus.in2_data  = d[2];
        bus.in3_data  = d[3];
        e = model_expect(v, o_rdy);
        exp_q.push_back(e);
        rdy_exp = e.rdy;
        @(posedge clk);
        model_step(v, o_rdy);
        #1;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a = {bus.out_valid, bus.out_data, bus.grant, bus.in_ready, bus.busy};
                log_q.push_back(mon_a);
                checks++;
                if (mon_a.ov === mon_e.ov && mon_a.grant === mon_e.grant &&
                    mon_a.rdy === mon_e.rdy && mon_a.busy === mon_e.busy &&
                    (!mon_e.ov || mon_a.data === mon_e.data)) begin
                    passed++;
                end else begin
                    $display("FAIL cycle_%0d: got ov=%b data=%h grant=%b in_ready=%b busy=%b, want ov=%b data=%h grant=%b in_ready=%b busy=%b",
                             mon_cyc, mon_a.ov, mon_a.data, mon_a.grant, mon_a.rdy, mon_a.busy,
                             mon_e.ov, mon_e.data, mon_e.grant, mon_e.rdy, mon_e.busy);
                end
                mon_cyc++;
            end
        end
    end

    initial begin : stim
`ifdef MUX4_ARB_BURST_EN
        t1_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        t5_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
`else
        t1_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        t5_exp = '{4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0001, 4'b1000};
`endif
        for (int i = 0; i < 4; i++) d[i] = '0;
        bus.in_valid  = 4'b0000;
        bus.out_ready = 1'b0;
        bus.in0_data  = '0;
        bus.in1_data  = '0;
        bus.in2_data  = '0;
        bus.in3_data  = '0;
        pend          = 4'b0000;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_in_ready",  32'(bus.in_ready),  32'd0);
        check("reset_grant",     32'(bus.grant),     32'd0);
        check("reset_busy",      32'(bus.busy),      32'd0);
        rst_n = 1'b1;

        // All four requesting with a ready sink: rotation from port 0, no bubbles.
        d[0] = 8'h10; d[1] = 8'h11; d[2] = 8'h12; d[3] = 8'h13;
        base = log_q.size();
        repeat (6) cycle(4'b1111, 1'b1, r);
        for (int k = 0; k < 5; k++)
            check($sformatf("t1_grant%0d", k), 32'(log_q[base + 1 + k].grant), 32'(t1_exp[k]));
        repeat (2) cycle(4'b0000, 1'b1, r);

        // Stalled sink: data held, no ready back to the producer, then one beat.
        d[2] = 8'hA5;
        base = log_q.size();
        cycle(4'b0100, 1'b0, r);
        repeat (3) cycle(4'b0100, 1'b0, r);
        cycle(4'b0100, 1'b1, r);
        repeat (2) cycle(4'b0000, 1'b1, r);
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("t2_valid%0d", k), 32'(log_q[base + k].ov),   32'd1);
            check($sformatf("t2_data%0d", k),  32'(log_q[base + k].data), 32'hA5);
            check($sformatf("t2_rdy%0d", k),   32'(log_q[base + k].rdy),  32'd0);
        end
        check("t2_xfer_rdy", 32'(log_q[base + 4].rdy), 32'b0100);

        // Granted port 1 withdraws; port 2 then wins over port 1.
        base = log_q.size();
        cycle(4'b0010, 1'b1, r);
        cycle(4'b0000, 1'b1, r);
        cycle(4'b0110, 1'b1, r);
        cycle(4'b0110, 1'b1, r);
        repeat (2) cycle(4'b0000, 1'b1, r);
        check("t3_withdraw_valid", 32'(log_q[base + 1].ov),    32'd0);
        check("t3_idle_grant",     32'(log_q[base + 2].grant), 32'd0);
        check("t3_winner",         32'(log_q[base + 3].grant), 32'b0100);

        // Asynchronous reset while a stalled beat is on the output.
        cycle(4'b1000, 1'b0, r);
        cycle(4'b1000, 1'b0, r);
        rst_n = 1'b0;
        #1;
        check("t4_out_valid", 32'(bus.out_valid), 32'd0);
        check("t4_in_ready",  32'(bus.in_ready),  32'd0);
        check("t4_grant",     32'(bus.grant),     32'd0);
        check("t4_busy",      32'(bus.busy),      32'd0);
        m_owner = -1;
        m_last  = 3;
        m_beats = 0;
        bus.in_valid = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Ports 0 and 3 both always requesting.
        d[0] = 8'h50; d[3] = 8'h53;
        base = log_q.size();
        repeat (9) cycle(4'b1001, 1'b1, r);
        for (int k = 0; k < 8; k++)
            check($sformatf("t5_grant%0d", k), 32'(log_q[base + 1 + k].grant), 32'(t5_exp[k]));
        repeat (2) cycle(4'b0000, 1'b1, r);

        // Random producers holding data until accepted, with occasional withdrawals.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 9) < 4) begin
                    pend[i] = 1'b1;
                    d[i]    = N'($urandom);
                end else if (pend[i] && $urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            ordy = ($urandom_range(0, 9) < 7);
            cycle(pend, ordy, r);
            pend = pend & ~r;
        end

        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
